// File: rtl/qam_tx_pkg.sv
// rtl/qam_tx_pkg.sv - shared constants, coefficient table and state type for the QAM interpolator
package qam_tx_pkg;

    localparam int SPS_DEF = 8;
    localparam int TPP_DEF = 4;
    localparam int CW_DEF  = 10;
    localparam int OW_DEF  = 3 + CW_DEF + $clog2(TPP_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Raised-cosine prototype (rolloff 0.5), centre tap at index 12, unity gain scaled to 511.
    // Zero crossings fall one symbol (8 samples) either side of the centre; 25..31 pad to 32 taps.
    localparam logic signed [CW_DEF-1:0] RC_COEF [0:31] = '{
        -10'sd61,  -10'sd68,  -10'sd63,  -10'sd41,  10'sd0,    10'sd59,   10'sd134,  10'sd219,
         10'sd307,  10'sd388,  10'sd453,  10'sd496,  10'sd511,  10'sd496,  10'sd453,  10'sd388,
         10'sd307,  10'sd219,  10'sd134,  10'sd59,   10'sd0,   -10'sd41,  -10'sd63,  -10'sd68,
        -10'sd61,   10'sd0,    10'sd0,    10'sd0,    10'sd0,    10'sd0,    10'sd0,    10'sd0
    };

    // DC gain of each polyphase branch: sum over k of RC_COEF[k*8+p].
    localparam logic signed [OW_DEF-1:0] PHASE_SUM [0:7] = '{
        15'sd492, 15'sd539, 15'sd524, 15'sd514, 15'sd511, 15'sd514, 15'sd524, 15'sd539
    };

endpackage

// File: rtl/qam_polyphase_interp_if.sv
// rtl/qam_polyphase_interp_if.sv - symbol input and shaped sample output bundle
interface qam_polyphase_interp_if #(
    parameter int OW = 15
);
    logic                 sym_valid;
    logic signed [2:0]    I_in;
    logic signed [2:0]    Q_in;
    logic signed [OW-1:0] I_out;
    logic signed [OW-1:0] Q_out;
    logic                 out_valid;
    logic                 early_err;
    logic                 late_err;

    modport master (
        output sym_valid, I_in, Q_in,
        input  I_out, Q_out, out_valid, early_err, late_err
    );

    modport slave (
        input  sym_valid, I_in, Q_in,
        output I_out, Q_out, out_valid, early_err, late_err
    );
endinterface

// File: rtl/qam_fir_branch.sv
// rtl/qam_fir_branch.sv - one rail: symbol delay line plus parallel polyphase MAC
module qam_fir_branch
    import qam_tx_pkg::*;
#(
    parameter int SPS = SPS_DEF,
    parameter int TPP = TPP_DEF,
    parameter int CW  = CW_DEF,
    parameter int OW  = 3 + CW + $clog2(TPP),
    parameter int PW  = $clog2(SPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift,
    input  logic signed [2:0]    din,
    input  logic [PW-1:0]        phase,
    output logic signed [OW-1:0] acc
);
    localparam int IW = $clog2(SPS * TPP);

    logic signed [2:0]      x    [TPP];
    logic signed [3+CW-1:0] prod [TPP];
    logic [IW-1:0]          idx  [TPP];

    // Symbol delay line: newest symbol in x[0], advanced once per symbol period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TPP; k++) x[k] <= '0;
        end else if (shift) begin
            x[0] <= din;
            for (int k = 1; k < TPP; k++) x[k] <= x[k-1];
        end
    end

    // All taps of the current phase are multiplied in parallel and summed at full width.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TPP; k++) begin
            idx[k]  = IW'(k * SPS) + IW'(phase);
            prod[k] = x[k] * RC_COEF[idx[k]];
            acc     = acc + {{(OW-3-CW){prod[k][3+CW-1]}}, prod[k]};
        end
    end
endmodule

// File: rtl/qam_polyphase_interp.sv
// rtl/qam_polyphase_interp.sv - 16QAM symbol upsampler with raised-cosine polyphase shaping
module qam_polyphase_interp
    import qam_tx_pkg::*;
#(
    parameter int SPS = SPS_DEF,
    parameter int TPP = TPP_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    qam_polyphase_interp_if.slave  bus
);
    localparam int OW = 3 + CW + $clog2(TPP);
    localparam int PW = $clog2(SPS);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SPS - 1);

    run_state_t           state, state_nxt;
    logic [PW-1:0]        phase, phase_nxt;
    logic                 shift;
    logic signed [2:0]    din_i, din_q;
    logic                 early_set, late_set;
    logic                 early_r, late_r, valid_r;
    logic signed [OW-1:0] acc_i, acc_q;
    logic signed [OW-1:0] i_out_r, q_out_r;

    // Phase sequencing: a symbol (real or an inserted zero) restarts phase 0 and shifts the delay line.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        shift     = 1'b0;
        din_i     = '0;
        din_q     = '0;
        early_set = 1'b0;
        late_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.sym_valid) begin
                    shift     = 1'b1;
                    din_i     = bus.I_in;
                    din_q     = bus.Q_in;
                    phase_nxt = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.sym_valid) begin
                    shift     = 1'b1;
                    din_i     = bus.I_in;
                    din_q     = bus.Q_in;
                    phase_nxt = '0;
                    early_set = (phase != LAST_PHASE);
                end else if (phase == LAST_PHASE) begin
                    shift     = 1'b1;
                    phase_nxt = '0;
                    late_set  = 1'b1;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, phase and sticky timing-error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            early_r <= 1'b0;
            late_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            early_r <= early_r | early_set;
            late_r  <= late_r | late_set;
        end
    end

    qam_fir_branch #(.SPS(SPS), .TPP(TPP), .CW(CW), .OW(OW), .PW(PW)) u_branch_i (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .din   (din_i),
        .phase (phase),
        .acc   (acc_i)
    );

    qam_fir_branch #(.SPS(SPS), .TPP(TPP), .CW(CW), .OW(OW), .PW(PW)) u_branch_q (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .din   (din_q),
        .phase (phase),
        .acc   (acc_q)
    );

    // Output register: samples are forced to zero while idle so the DAC sees silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_out_r <= '0;
            q_out_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= (state == ST_RUN);
            i_out_r <= (state == ST_RUN) ? acc_i : '0;
            q_out_r <= (state == ST_RUN) ? acc_q : '0;
        end
    end

    assign bus.I_out     = i_out_r;
    assign bus.Q_out     = q_out_r;
    assign bus.out_valid = valid_r;
    assign bus.early_err = early_r;
    assign bus.late_err  = late_r;
endmodule

// File: tb/tb_qam_polyphase_interp.sv
// tb/tb_qam_polyphase_interp.sv - self-checking bench for qam_polyphase_interp
module tb_qam_polyphase_interp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qam_polyphase_interp_if #(.OW(15)) bus();

    qam_polyphase_interp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int tb_rc [32] = '{-61, -68, -63, -41, 0, 59, 134, 219, 307, 388, 453, 496, 511, 496, 453, 388,
                       307, 219, 134, 59, 0, -41, -63, -68, -61, 0, 0, 0, 0, 0, 0, 0};
    int tb_psum [8] = '{492, 539, 524, 514, 511, 514, 524, 539};

    // Reference: history of the last four symbols that entered the filter and samples since the newest one.
    int m_hi [4];
    int m_hq [4];
    int m_age;
    bit m_run, m_early, m_late;
    logic signed [14:0] exp_i, exp_q;
    logic exp_v, exp_e, exp_l;

    task automatic step(input logic r, input logic v, input logic signed [2:0] i, input logic signed [2:0] q);
        int si, sq;
        bit enter;
        rst           = r;
        bus.sym_valid = v;
        bus.I_in      = i;
        bus.Q_in      = q;
        if (r) begin
            m_run = 0; m_age = 0; m_early = 0; m_late = 0;
            for (int k = 0; k < 4; k++) begin m_hi[k] = 0; m_hq[k] = 0; end
            exp_i = '0; exp_q = '0; exp_v = 1'b0; exp_e = 1'b0; exp_l = 1'b0;
        end else begin
            si = 0; sq = 0;
            if (m_run)
                for (int k = 0; k < 4; k++) begin
                    si += tb_rc[k*8 + m_age] * m_hi[k];
                    sq += tb_rc[k*8 + m_age] * m_hq[k];
                end
            exp_i = 15'(si);
            exp_q = 15'(sq);
            exp_v = m_run;
            enter = v || (m_run && m_age == 7);
            if (enter) begin
                if (m_run && v && m_age != 7) m_early = 1;
                if (m_run && !v) m_late = 1;
                for (int k = 3; k > 0; k--) begin m_hi[k] = m_hi[k-1]; m_hq[k] = m_hq[k-1]; end
                m_hi[0] = v ? int'(i) : 0;
                m_hq[0] = v ? int'(q) : 0;
                m_age = 0;
                m_run = 1;
            end else if (m_run) begin
                m_age++;
            end
            exp_e = m_early;
            exp_l = m_late;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [2:0] pick_sym();
        case ($urandom_range(0, 3))
            0:       return 3'sb101;
            1:       return 3'sb111;
            2:       return 3'sb001;
            default: return 3'sb011;
        endcase
    endfunction

    task automatic do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 3'sd0, 3'sd0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));
            n_tests++;
            if ({bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err} !== 33'd0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: I=%0d Q=%0d v=%b e=%b l=%b, required all 0",
                         c, bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err);
            end
        end
    endtask

    task automatic impulse_run(input string tag);
        for (int c = 0; c <= 25; c++) begin
            step(1'b0, (c % 8 == 0), (c == 0) ? 3'sb011 : 3'sd0, (c == 0) ? 3'sb101 : 3'sd0);
            if (c >= 1) begin
                n_tests++;
                if (bus.I_out !== 15'(3 * tb_rc[c-1]) || bus.Q_out !== 15'(-3 * tb_rc[c-1])) begin
                    n_fail++;
                    $display("FAIL %s j=%0d: I=%0d Q=%0d, required I=%0d Q=%0d",
                             tag, c - 1, bus.I_out, bus.Q_out, 3 * tb_rc[c-1], -3 * tb_rc[c-1]);
                end
                if (c == 13) begin
                    n_tests++;
                    if (bus.I_out !== 15'sd1533) begin
                        n_fail++;
                        $display("FAIL %s peak: I=%0d, required 1533", tag, bus.I_out);
                    end
                end
            end
        end
    endtask

    task automatic test_impulse();
        do_reset();
        impulse_run("impulse");
    endtask

    task automatic test_dc();
        do_reset();
        for (int c = 0; c < 80; c++) begin
            step(1'b0, (c % 8 == 0), 3'sb001, 3'sb111);
            if (c >= 1 && (c - 1) / 8 >= 3) begin
                n_tests++;
                if (bus.I_out !== 15'(tb_psum[(c-1)%8]) || bus.Q_out !== 15'(-tb_psum[(c-1)%8])) begin
                    n_fail++;
                    $display("FAIL dc p=%0d: I=%0d Q=%0d, required I=%0d Q=%0d",
                             (c - 1) % 8, bus.I_out, bus.Q_out, tb_psum[(c-1)%8], -tb_psum[(c-1)%8]);
                end
            end
        end
        n_tests++;
        if (bus.early_err !== 1'b0 || bus.late_err !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dc_flags: e=%b l=%b v=%b, required 0 0 1", bus.early_err, bus.late_err, bus.out_valid);
        end
    endtask

    task automatic test_late();
        int s [41];
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            s[c] = (c == 0 || c == 8 || c == 16 || c == 32) ? int'(pick_sym()) : 0;
            step(1'b0, (s[c] != 0), 3'(s[c]), 3'(-s[c]));
            if (c == 23 || c == 24) begin
                n_tests++;
                if (bus.late_err !== (c == 24) || bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL late_flag c=%0d: l=%b v=%b, required l=%b v=1", c, bus.late_err, bus.out_valid, c == 24);
                end
            end
            if (c == 25) begin
                n_tests++;
                if (bus.I_out !== 15'(tb_rc[8]*s[16] + tb_rc[16]*s[8] + tb_rc[24]*s[0])) begin
                    n_fail++;
                    $display("FAIL late_zero: I=%0d, required %0d", bus.I_out,
                             tb_rc[8]*s[16] + tb_rc[16]*s[8] + tb_rc[24]*s[0]);
                end
            end
            if (c == 33) begin
                n_tests++;
                if (bus.I_out !== 15'(tb_rc[0]*s[32] + tb_rc[16]*s[16] + tb_rc[24]*s[8]) || bus.early_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL late_wrap: I=%0d e=%b, required I=%0d e=0", bus.I_out, bus.early_err,
                             tb_rc[0]*s[32] + tb_rc[16]*s[16] + tb_rc[24]*s[8]);
                end
            end
            n_tests++;
            if ({bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err} !== {exp_i, exp_q, exp_v, exp_e, exp_l}) begin
                n_fail++;
                $display("FAIL late_model c=%0d: got I=%0d Q=%0d v=%b e=%b l=%b, required I=%0d Q=%0d v=%b e=%b l=%b",
                         c, bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err, exp_i, exp_q, exp_v, exp_e, exp_l);
            end
        end
    endtask

    task automatic test_early();
        int s [16];
        do_reset();
        for (int c = 0; c < 16; c++) begin
            s[c] = (c == 0 || c == 8 || c == 13) ? int'(pick_sym()) : 0;
            step(1'b0, (s[c] != 0), 3'(s[c]), 3'(s[c]));
            if (c == 12 || c == 13) begin
                n_tests++;
                if (bus.early_err !== (c == 13) || bus.late_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_flag c=%0d: e=%b l=%b, required e=%b l=0", c, bus.early_err, bus.late_err, c == 13);
                end
            end
            if (c == 14) begin
                n_tests++;
                if (bus.I_out !== 15'(tb_rc[0]*s[13] + tb_rc[8]*s[8] + tb_rc[16]*s[0])) begin
                    n_fail++;
                    $display("FAIL early_phase0: I=%0d, required %0d", bus.I_out,
                             tb_rc[0]*s[13] + tb_rc[8]*s[8] + tb_rc[16]*s[0]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int c = 0; c < 12; c++) step(1'b0, (c % 8 == 0), pick_sym(), pick_sym());
        step(1'b1, 1'b0, 3'sd0, 3'sd0);
        n_tests++;
        if ({bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err} !== 33'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: I=%0d Q=%0d v=%b e=%b l=%b, required all 0",
                     bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err);
        end
        step(1'b0, 1'b0, 3'sd0, 3'sd0);
        impulse_run("restart");
    endtask

    task automatic test_random();
        int gap;
        logic v;
        do_reset();
        gap = 0;
        for (int c = 0; c < 600; c++) begin
            v = (gap == 0);
            if (v) begin
                case ($urandom_range(0, 9))
                    0, 1:    gap = $urandom_range(0, 6);
                    2:       gap = $urandom_range(8, 16);
                    default: gap = 7;
                endcase
            end else begin
                gap--;
            end
            step(($urandom_range(0, 299) == 0), v, pick_sym(), pick_sym());
            n_tests++;
            if ({bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err} !== {exp_i, exp_q, exp_v, exp_e, exp_l}) begin
                n_fail++;
                $display("FAIL random c=%0d: got I=%0d Q=%0d v=%b e=%b l=%b, required I=%0d Q=%0d v=%b e=%b l=%b",
                         c, bus.I_out, bus.Q_out, bus.out_valid, bus.early_err, bus.late_err, exp_i, exp_q, exp_v, exp_e, exp_l);
            end
        end
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.I_in      = '0;
        bus.Q_in      = '0;
        test_reset();
        test_impulse();
        test_dc();
        test_late();
        test_early();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
